hazard_scoreboard: RTL and testbench

- Upstream neighbour of the pipeline stall controller in the 5-stage MIPS core.
- Tracks in-flight register writes in the EX, MEM and WB slots with an internal shift pipeline that mirrors the datapath.
- Compares the ID-stage source registers against that pipeline and raises idstall, which the stall controller stretches into the pipeline stall.
- Also feeds bubbles into its own EX slot while stalled and counts stall events for performance monitoring.

---
 rtl/hazard_scoreboard.sv | 92 +++++++++
 tb/tb_hazard_scoreboard.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : RAW hazard detector for the 5-stage core; shadows EX/MEM/WB writes
//            and counts new stall events.
// Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic [REG_AW-1:0] id_wdest,
    input  logic              stall,
    input  logic              flush,
    output logic              idstall,
    output logic              wb_wreg,
    output logic [REG_AW-1:0] wb_dest,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [REG_AW-1:0] c_reg_zero = '0;
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

    logic              r_ex_v;
    logic [REG_AW-1:0] r_ex_dest;
    logic              r_mem_v;
    logic [REG_AW-1:0] r_mem_dest;
    logic              r_wb_v;
    logic [REG_AW-1:0] r_wb_dest;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_hit_rs;
    logic w_hit_rt;
    logic w_idstall;
    logic w_ex_load;
    logic w_new_event;

    // WB is deliberately not compared: the regfile is write-first.
    assign w_hit_rs = id_use_rs && (id_rs != c_reg_zero) &&
                      ((r_ex_v && (r_ex_dest == id_rs)) || (r_mem_v && (r_mem_dest == id_rs)));
    assign w_hit_rt = id_use_rt && (id_rt != c_reg_zero) &&
                      ((r_ex_v && (r_ex_dest == id_rt)) || (r_mem_v && (r_mem_dest == id_rt)));
    assign w_idstall = id_valid && !flush && (w_hit_rs || w_hit_rt);

    // The first hazard cycle has stall=0, so idstall itself must block capture.
    assign w_ex_load = id_valid && id_wreg && (id_wdest != c_reg_zero) &&
                       !stall && !w_idstall && !flush;
    assign w_new_event = w_idstall && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_v     <= 1'b0;
            r_ex_dest  <= '0;
            r_mem_v    <= 1'b0;
            r_mem_dest <= '0;
            r_wb_v     <= 1'b0;
            r_wb_dest  <= '0;
        end else begin
            r_wb_v     <= r_mem_v;
            r_wb_dest  <= r_mem_dest;
            r_mem_v    <= r_ex_v;
            r_mem_dest <= r_ex_dest;
            r_ex_v     <= w_ex_load;
            r_ex_dest  <= w_ex_load ? id_wdest : c_reg_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_new_event && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign idstall   = w_idstall;
    assign wb_wreg   = r_wb_v;
    assign wb_dest   = r_wb_dest;
    assign busy      = r_ex_v || r_mem_v;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed self-checking bench for hazard_scoreboard (CNT_W=4 build).
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wreg;
    logic [REG_AW-1:0] id_wdest;
    logic              stall;
    logic              flush;
    logic              idstall;
    logic              wb_wreg;
    logic [REG_AW-1:0] wb_dest;
    logic              busy;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    // Stall-controller model: registered stall held for two cycles after a new idstall.
    logic       use_model;
    logic       stall_man;
    logic [1:0] r_win;

    assign stall = use_model ? (r_win != 2'd0) : stall_man;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_win <= 2'd0;
        else if (r_win != 2'd0)    r_win <= r_win - 2'd1;
        else if (idstall)          r_win <= 2'd2;
    end

    hazard_scoreboard #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_wreg   (id_wreg),
        .id_wdest  (id_wdest),
        .stall     (stall),
        .flush     (flush),
        .idstall   (idstall),
        .wb_wreg   (wb_wreg),
        .wb_dest   (wb_dest),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input int rs, input int rt, input logic urs,
                          input logic urt, input logic wr, input int wd);
        id_valid  = v;
        id_rs     = REG_AW'(rs);
        id_rt     = REG_AW'(rt);
        id_use_rs = urs;
        id_use_rt = urt;
        id_wreg   = wr;
        id_wdest  = REG_AW'(wd);
        #1;
    endtask

    task automatic drain();
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        use_model = 1'b0; stall_man = 1'b0; flush = 1'b0;
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        repeat (2) tick();
        checks++; if (busy !== 1'b0 || wb_wreg !== 1'b0 || wb_dest !== '0 || stall_cnt !== '0) begin
            errors++; $display("FAIL reset_state: busy=%0b wb_wreg=%0b wb_dest=%0d cnt=%0d required 0/0/0/0", busy, wb_wreg, wb_dest, stall_cnt);
        end
        rst_n = 1'b1;
        tick();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1); tick();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 2); tick();
        // EX=r2, MEM=r1; consumer reads r1 and r2
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 3);
        checks++; if (idstall !== 1'b1) begin
            errors++; $display("FAIL pre_reset_idstall: got %0b required 1", idstall);
        end
        tick();
        checks++; if (stall_cnt !== 4'd1 || idstall !== 1'b1 || busy !== 1'b1 || wb_wreg !== 1'b1) begin
            errors++; $display("FAIL pre_reset_state: cnt=%0d idstall=%0b busy=%0b wb_wreg=%0b required 1/1/1/1", stall_cnt, idstall, busy, wb_wreg);
        end
        rst_n = 1'b0; #1;
        checks++; if (idstall !== 1'b0 || busy !== 1'b0 || wb_wreg !== 1'b0 || wb_dest !== '0 || stall_cnt !== '0) begin
            errors++; $display("FAIL async_reset: idstall=%0b busy=%0b wb_wreg=%0b wb_dest=%0d cnt=%0d required all 0", idstall, busy, wb_wreg, wb_dest, stall_cnt);
        end
        rst_n = 1'b1; #1;
        checks++; if (idstall !== 1'b0) begin
            errors++; $display("FAIL stale_hazard_release: got %0b required 0", idstall);
        end
        tick();
        checks++; if (idstall !== 1'b0 || stall_cnt !== '0) begin
            errors++; $display("FAIL stale_hazard_tick: idstall=%0b cnt=%0d required 0/0", idstall, stall_cnt);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        use_model = 1'b1;
        set_id(1'b1, 4, 0, 1'b1, 1'b0, 1'b1, 1);          // lw r1,0(r4)
        checks++; if (idstall !== 1'b0) begin
            errors++; $display("FAIL b2b_c0_idstall: got %0b required 0", idstall);
        end
        tick();
        set_id(1'b1, 1, 3, 1'b1, 1'b1, 1'b1, 2);          // add r2,r1,r3
        checks++; if (idstall !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL b2b_c1: idstall=%0b stall=%0b required 1/0", idstall, stall);
        end
        tick();
        checks++; if (idstall !== 1'b1 || stall !== 1'b1 || busy !== 1'b1 || stall_cnt !== 4'd1) begin
            errors++; $display("FAIL b2b_c2: idstall=%0b stall=%0b busy=%0b cnt=%0d required 1/1/1/1", idstall, stall, busy, stall_cnt);
        end
        tick();
        checks++; if (idstall !== 1'b0 || wb_wreg !== 1'b1 || wb_dest !== 5'd1 || busy !== 1'b0 || stall_cnt !== 4'd1) begin
            errors++; $display("FAIL b2b_c3: idstall=%0b wb_wreg=%0b wb_dest=%0d busy=%0b cnt=%0d required 0/1/1/0/1", idstall, wb_wreg, wb_dest, busy, stall_cnt);
        end
        tick();
        checks++; if (stall !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_c4: stall=%0b busy=%0b required 0/0", stall, busy);
        end
        tick();
        checks++; if (busy !== 1'b1 || stall_cnt !== 4'd1) begin
            errors++; $display("FAIL b2b_capture: busy=%0b cnt=%0d required 1/1", busy, stall_cnt);
        end
        drain();
        use_model = 1'b0;
    endtask

    task automatic test_zero_noread();
        stall_man = 1'b0;
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0); tick();  // writes r0
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL r0_slot: busy=%0b required 0", busy);
        end
        set_id(1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 0);
        checks++; if (idstall !== 1'b0) begin
            errors++; $display("FAIL r0_hazard: got %0b required 0", idstall);
        end
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 7); tick();  // writes r7
        set_id(1'b1, 0, 7, 1'b1, 1'b1, 1'b0, 0);
        checks++; if (idstall !== 1'b1) begin
            errors++; $display("FAIL rt_used_hazard: got %0b required 1", idstall);
        end
        set_id(1'b1, 0, 7, 1'b1, 1'b0, 1'b0, 0);
        checks++; if (idstall !== 1'b0) begin
            errors++; $display("FAIL rt_unused_hazard: got %0b required 0", idstall);
        end
        drain();
    endtask

    task automatic test_distance2();
        use_model = 1'b1;
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 9); tick();
        set_id(1'b1, 11, 12, 1'b1, 1'b1, 1'b1, 10);
        checks++; if (idstall !== 1'b0) begin
            errors++; $display("FAIL d2_indep: got %0b required 0", idstall);
        end
        tick();
        set_id(1'b1, 9, 0, 1'b1, 1'b0, 1'b1, 13);
        checks++; if (idstall !== 1'b1) begin
            errors++; $display("FAIL d2_mem_hit: got %0b required 1", idstall);
        end
        tick();
        checks++; if (idstall !== 1'b0 || stall_cnt !== 4'd2) begin
            errors++; $display("FAIL d2_after: idstall=%0b cnt=%0d required 0/2", idstall, stall_cnt);
        end
        drain();
        use_model = 1'b0;
    endtask

    task automatic test_flush();
        stall_man = 1'b0;
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5); tick();
        set_id(1'b1, 5, 0, 1'b1, 1'b0, 1'b1, 6);
        checks++; if (idstall !== 1'b1) begin
            errors++; $display("FAIL flush_pre: got %0b required 1", idstall);
        end
        flush = 1'b1; #1;
        checks++; if (idstall !== 1'b0) begin
            errors++; $display("FAIL flush_idstall: got %0b required 0", idstall);
        end
        tick();
        flush = 1'b0;
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        checks++; if (busy !== 1'b1) begin
            errors++; $display("FAIL flush_mem_busy: got %0b required 1", busy);
        end
        tick();
        checks++; if (busy !== 1'b0 || stall_cnt !== 4'd2) begin
            errors++; $display("FAIL flush_bubble: busy=%0b cnt=%0d required 0/2", busy, stall_cnt);
        end
        drain();
    endtask

    task automatic test_saturation();
        stall_man = 1'b0;
        // each pass yields two new events (EX match, then MEM match)
        for (int i = 0; i < 10; i++) begin
            set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 8); tick();
            set_id(1'b1, 8, 0, 1'b1, 1'b0, 1'b0, 0); tick(); tick();
            if (i == 5) begin
                checks++; if (stall_cnt !== 4'd14) begin
                    errors++; $display("FAIL cnt_midway: got %0d required 14", stall_cnt);
                end
            end
        end
        checks++; if (stall_cnt !== 4'd15) begin
            errors++; $display("FAIL cnt_saturate: got %0d required 15", stall_cnt);
        end
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 8); tick();
        set_id(1'b1, 8, 0, 1'b1, 1'b0, 1'b0, 0); tick();
        checks++; if (stall_cnt !== 4'd15) begin
            errors++; $display("FAIL cnt_no_wrap: got %0d required 15", stall_cnt);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_zero_noread();
        test_distance2();
        test_flush();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
